// File: rtl/opcode_encoder_if.sv
// Request/issue bundle for opcode_encoder: hot-line request handshake in,
// encoded opcode handshake out, plus error and occupancy status.
interface opcode_encoder_if #(
   parameter int unsigned LVL_W = 3
);
   logic [5:0]       req_hot;
   logic             req_valid;
   logic             req_ready;
   logic [4:0]       op_code;
   logic             op_valid;
   logic             op_ready;
   logic             err_sticky;
   logic [7:0]       err_count;
   logic [LVL_W-1:0] level;

   // Command producer / ALU front end side
   modport master (
      output req_hot, req_valid, op_ready,
      input  req_ready, op_code, op_valid, err_sticky, err_count, level
   );

   // Encoder side
   modport slave (
      input  req_hot, req_valid, op_ready,
      output req_ready, op_code, op_valid, err_sticky, err_count, level
   );
endinterface

// File: rtl/opcode_encoder.sv
// One-hot command lines -> 5-bit ALU opcode, buffered in a DEPTH-entry FIFO.
// Optional macro OPCODE_ENCODER_PRIORITY_EN: multi-hot legal, lowest set bit wins.
module opcode_encoder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   opcode_encoder_if.slave  bus
);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned HOT_W = 6;
   localparam int unsigned OP_W  = 5;
   localparam int unsigned CNT_W = 3;

   logic [OP_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             err_sticky_q, err_sticky_d;
   logic [7:0]       err_count_q, err_count_d;

   logic [CNT_W-1:0] ones;
   logic [OP_W-1:0]  enc;
   logic             found;
   logic             legal;
   logic             accept;
   logic             push;
   logic             pop;
   logic             bad_req;

   // Count set bits and locate the lowest one in a single pass
   always_comb begin
      ones  = '0;
      enc   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(HOT_W); i++) begin
         if (bus.req_hot[i]) begin
            ones = ones + CNT_W'(1);
            if (!found) begin
               enc   = OP_W'(i);
               found = 1'b1;
            end
         end
      end
   end

`ifdef OPCODE_ENCODER_PRIORITY_EN
   assign legal = found;
`else
   assign legal = (ones == CNT_W'(1));
`endif

   // Pop is evaluated first so a full FIFO can accept in the same cycle it drains
   assign pop           = (level_q != '0) && bus.op_ready;
   assign bus.req_ready = reset_n &&
                          ((level_q < LVL_W'(DEPTH)) || pop);
   assign accept        = bus.req_valid && bus.req_ready;
   assign push          = accept && legal;
   assign bad_req       = accept && !legal;

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      level_d      = level_q;
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      if (bad_req) begin
         err_sticky_d = 1'b1;
         if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         level_q      <= '0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         level_q      <= level_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
         if (push) mem_q[wr_ptr_q] <= enc;
      end
   end

   assign bus.op_code    = mem_q[rd_ptr_q];
   assign bus.op_valid   = (level_q != '0);
   assign bus.err_sticky = err_sticky_q;
   assign bus.err_count  = err_count_q;
   assign bus.level      = level_q;
endmodule

// File: tb/tb_opcode_encoder.sv
// Directed + randomized bench for opcode_encoder against a queue-based reference.
module tb_opcode_encoder;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   opcode_encoder_if #(.LVL_W(PTR_W + 1)) bus ();

   opcode_encoder #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   int q[$];
   bit m_sticky   = 1'b0;
   int m_errcnt   = 0;
   bit just_reset = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int count_ones(input logic [5:0] h);
      int n = 0;
      for (int i = 0; i < 6; i++) if (h[i]) n++;
      return n;
   endfunction

   function automatic int lowest(input logic [5:0] h);
      for (int i = 0; i < 6; i++) if (h[i]) return i;
      return 0;
   endfunction

   function automatic bit is_legal(input logic [5:0] h);
`ifdef OPCODE_ENCODER_PRIORITY_EN
      return count_ones(h) >= 1;
`else
      return count_ones(h) == 1;
`endif
   endfunction

   // One clock: drive inputs, check state left by the previous edge, advance model
   task automatic step(input logic [5:0] hot, input logic vld, input logic ordy, input logic rstn);
      bit exp_rdy;
      bit pop_m;
      @(negedge clock);
      bus.req_hot   = hot;
      bus.req_valid = vld;
      bus.op_ready  = ordy;
      reset_n       = rstn;
      #1;
      if (!rstn) begin
         chk("req_ready_in_reset", 32'(bus.req_ready), 32'd0);
      end else begin
         exp_rdy = (q.size() < int'(DEPTH)) || (ordy && q.size() == int'(DEPTH));
         chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         chk("op_valid", 32'(bus.op_valid), 32'(q.size() != 0));
         chk("level", 32'(bus.level), 32'(q.size()));
         chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
         chk("err_count", 32'(bus.err_count), 32'(m_errcnt));
         if (q.size() != 0) chk("op_code", 32'(bus.op_code), 32'(q[0]));
         if (just_reset) chk("op_code_after_reset", 32'(bus.op_code), 32'd0);
         just_reset = 1'b0;
         pop_m = (q.size() != 0) && ordy;
         if (pop_m) void'(q.pop_front());
         if (vld && exp_rdy) begin
            if (is_legal(hot)) q.push_back(lowest(hot));
            else begin
               m_sticky = 1'b1;
               if (m_errcnt < 255) m_errcnt++;
            end
         end
      end
      @(posedge clock);
      if (!rstn) begin
         q.delete();
         m_sticky   = 1'b0;
         m_errcnt   = 0;
         just_reset = 1'b1;
      end
   endtask

   initial begin
      logic [5:0] h;
      bus.req_hot   = '0;
      bus.req_valid = 1'b0;
      bus.op_ready  = 1'b0;

      // Reset for two cycles, then a single opcode through
      step(6'b0, 1'b0, 1'b0, 1'b0);
      step(6'b0, 1'b0, 1'b0, 1'b0);
      step(6'b000010, 1'b1, 1'b0, 1'b1);
      step(6'b0, 1'b0, 1'b0, 1'b1);
      step(6'b0, 1'b0, 1'b1, 1'b1);
      step(6'b0, 1'b0, 1'b0, 1'b1);

      // Fill, backpressure, full-FIFO pass-through, drain in order
      for (int i = 0; i < 4; i++) step(6'(1 << i), 1'b1, 1'b0, 1'b1);
      step(6'b000001, 1'b1, 1'b0, 1'b1);
      chk("full_level", 32'(bus.level), 32'd4);
      step(6'b000001, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(6'b0, 1'b0, 1'b1, 1'b1);

      // Illegal requests: zero-hot and multi-hot
      step(6'b000000, 1'b1, 1'b0, 1'b1);
      step(6'b000110, 1'b1, 1'b0, 1'b1);
      step(6'b0, 1'b0, 1'b1, 1'b1);
      step(6'b0, 1'b0, 1'b1, 1'b1);

      // Error counter saturation
      for (int i = 0; i < 300; i++) step(6'b0, 1'b1, 1'b1, 1'b1);
      step(6'b0, 1'b0, 1'b1, 1'b1);
      chk("err_count_saturated", 32'(bus.err_count), 32'hFF);

      // Streaming rotating one-hot at full rate
      for (int i = 0; i < 20; i++) begin
         step(6'(1 << (i % 6)), 1'b1, 1'b1, 1'b1);
         if (i > 0) chk("stream_level_le1", 32'(bus.level <= 3'd1), 32'd1);
      end
      step(6'b0, 1'b0, 1'b1, 1'b1);

      // Reset with three entries buffered
      for (int i = 0; i < 3; i++) step(6'(1 << (i + 2)), 1'b1, 1'b0, 1'b1);
      step(6'b0, 1'b0, 1'b0, 1'b1);
      step(6'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(6'b0, 1'b0, 1'b1, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    h = 6'(1 << $urandom_range(0, 5));
            2:       h = 6'b0;
            default: h = 6'($urandom);
         endcase
         step(h, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 99) != 0));
      end
      step(6'b0, 1'b0, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/opcode_encoder.md
Name: opcode_encoder

Overview:
Converts one-hot command lines back into the 5-bit ALU opcode. This is the inverse of the ALU hot-line decoder, where opcode k asserts hot-line k. Command producers present a 6-bit hot-line request through a valid/ready handshake. The block checks that the request is legal, encodes it, and buffers it in a small FIFO. It then issues opcodes to the ALU front end through a second valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  synchronous reset, active-low; sampled on the rising edge of clock.
- req_hot  input  6  one-hot command request; bit k means opcode k (bit0 ADD, bit1 SUB, bits 5:2 reserved).
- req_valid  input  1  req_hot is valid this cycle.
- req_ready  output  1  block can accept a request this cycle.
- op_code  output  5  encoded opcode at the FIFO head.
- op_valid  output  1  op_code is valid.
- op_ready  input  1  ALU consumes op_code this cycle.
- err_sticky  output  1  set by any illegal request; cleared only by reset.
- err_count  output  8  number of illegal requests; saturates at 255.
- level  output  PTR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Read pointer, write pointer and level go to 0.
  - op_valid=0, err_sticky=0, err_count=0.
  - req_ready=0 during the reset cycle only.
  - op_code is don't-care while op_valid=0, but is driven to 5'b00000.
  - Asserting reset mid-transfer discards all buffered opcodes. Nothing is issued on that edge.
- Accept: a request is accepted when req_valid && req_ready. The handshake is per-edge; a request is never accepted twice.
- req_ready = (level < DEPTH) or (level == DEPTH and the head is popped this cycle).
  - This is a combinational pass-through of op_ready when the FIFO is full.
  - The path op_ready -> req_ready is permitted.
- Legality:
  - Legal: exactly one bit of req_hot is set.
  - Illegal: zero bits set, or two or more bits set.
  - An accepted illegal request is consumed (the handshake completes) but is not written to the FIFO.
  - An illegal request sets err_sticky and increments err_count, saturating at 8'hFF.
- Encoding: for a legal req_hot with bit k set, the stored value is op_code = k, zero-extended to 5 bits. 000001 -> 00000, 000010 -> 00001, 100000 -> 00101.
- Output:
  - op_valid = (level != 0).
  - op_code = mem[rd_ptr], driven registered from the FIFO head with no combinational path from req_hot.
  - Pop occurs when op_valid && op_ready.
  - op_code and op_valid must stay stable until popped.
- Latency: an accepted legal request appears at op_code on the cycle after acceptance if the FIFO was empty. There is no empty-FIFO bypass.
- Simultaneous push and pop:
  - Level is unchanged; both pointers advance.
  - This is legal at level DEPTH (via the pass-through above) and at level 1.
  - At level 1 with a simultaneous push and pop, the next head is the new entry on the next cycle.
- Illegal request together with a pop: level decrements; only the error counters change on the request side.
- Pointers wrap modulo DEPTH. Full/empty are determined from level, not from pointer equality.
- Ordering: strict FIFO. No reordering or priority among buffered entries.
- op_ready while op_valid=0 is ignored.

Optional Feature:
- Macro: OPCODE_ENCODER_PRIORITY_EN.
- When defined:
  - A multi-hot request is legal and encodes the lowest set bit. Example: 000011 -> 00000.
  - Only an all-zero request is illegal and updates err_sticky/err_count.
- When undefined: the behaviour above applies; any multi-hot request is illegal.

Test Plan:
1. Reset then single op: reset_n=0 for 2 cycles, then 1. Push req_hot=000010 with op_ready=0.
   -> Next cycle op_valid=1, op_code=00001, level=1.
   -> Raise op_ready: op_valid=0 the following cycle.
2. Fill and backpressure: hold op_ready=0 and push 000001, 000010, 000100, 001000.
   -> level=4, req_ready=0.
   -> Fifth request held until op_ready=1; same cycle req_ready=1.
   -> Output order 0, 1, 2, 3, then 00000 for the fifth request.
3. Illegal requests: push 000000, then 000110.
   -> Both handshakes complete; level stays 0; err_sticky=1; err_count=2.
   -> With OPCODE_ENCODER_PRIORITY_EN defined: err_count=1 and op_code=00001 is issued.
4. Saturation: push 300 all-zero requests.
   -> err_count=255 and holds; err_sticky=1.
5. Streaming: op_ready=1 and req_valid=1 every cycle with a rotating one-hot across bits 0..5 for 20 cycles.
   -> One opcode out per cycle, 1-cycle lag, values 0..5 repeating, level never exceeds 1.
6. Reset mid-operation: level=3, then assert reset_n=0 for one cycle.
   -> level=0, op_valid=0, err_count=0.
   -> No stale opcode appears after release.
